// File: rtl/sram_arb_pkg.sv
// Shared defaults and helpers for the single-port SRAM arbiter.
// SRAM_ARB_RDATA_REG_EN adds a read-data register, which sets READ_LAT to 2.
package sram_arb_pkg;

    localparam int DEF_BITS       = 256;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_MASK_W     = DEF_BITS / 8;

`ifdef SRAM_ARB_RDATA_REG_EN
    localparam int READ_LAT = 2;
`else
    localparam int READ_LAT = 1;
`endif

    // The macro masks writes per bit, but requesters supply byte enables.
    function automatic logic [DEF_BITS-1:0] expand_mask(input logic [DEF_MASK_W-1:0] wbe);
        logic [DEF_BITS-1:0] m;
        m = '0;
        for (int k = 0; k < DEF_BITS; k++) begin
            m[k] = wbe[k/8];
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker. Grants the first active request at or after ptr,
// wrapping past NUM_REQ-1, and returns the grant as one-hot and as an index.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Shares one single-port SRAM macro among NUM_REQ round-robin requesters.
// Define SRAM_ARB_RDATA_REG_EN to register read data (latency 2 instead of 1).
module sram_1rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int BITS       = DEF_BITS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MASK_W     = DEF_MASK_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*BITS-1:0]      req_wdata,
    input  logic [NUM_REQ*MASK_W-1:0]    req_wbe,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [BITS-1:0]              rsp_rdata,
    output logic                         sram_ce,
    output logic                         sram_we,
    output logic [ADDR_WIDTH-1:0]        sram_addr,
    output logic [BITS-1:0]              sram_wd,
    output logic [BITS-1:0]              sram_w_mask,
    input  logic [BITS-1:0]              sram_rd,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: a request is taken on a clock edge where req_valid[i] and
    // req_ready[i] are both high; ready is one-hot or zero and is combinational
    // from req_valid and the round-robin pointer, so requesters must hold
    // req_* stable while valid and not ready.
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   g_idx;
    logic               g_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (g_idx),
        .grant_valid (g_valid)
    );

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BITS-1:0]       sel_wd;
    logic [MASK_W-1:0]     sel_wbe;
    logic                  rd_issue;

    always_comb begin
        int sel;
        sel      = int'(g_idx);
        sel_we   = req_we[sel];
        sel_addr = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wd   = req_wdata[sel*BITS +: BITS];
        sel_wbe  = req_wbe[sel*MASK_W +: MASK_W];
    end

    // Reset gates ready and ce directly so nothing can be accepted while rst_n is low.
    always_comb begin
        req_ready   = rst_n ? grant : '0;
        sram_ce     = rst_n & g_valid;
        sram_we     = sram_ce & sel_we;
        sram_addr   = g_valid ? sel_addr : '0;
        sram_wd     = g_valid ? sel_wd : '0;
        sram_w_mask = (g_valid && sel_we) ? expand_mask(sel_wbe) : '0;
        rd_issue    = sram_ce & ~sel_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (g_valid) begin
            rr_ptr <= (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
        end
    end

    // Read tags travel READ_LAT stages so the response finds its requester.
    logic [READ_LAT-1:0]            pipe_v;
    logic [READ_LAT-1:0][IDX_W-1:0] pipe_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            pipe_v[0]  <= rd_issue;
            pipe_id[0] <= g_idx;
            for (int s = 1; s < READ_LAT; s++) begin
                pipe_v[s]  <= pipe_v[s-1];
                pipe_id[s] <= pipe_id[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (pipe_v[READ_LAT-1]) begin
            rsp_valid[pipe_id[READ_LAT-1]] = 1'b1;
        end
        busy = |pipe_v;
    end

`ifdef SRAM_ARB_RDATA_REG_EN
    logic [BITS-1:0] rdata_q;

    // Macro data is only meaningful the cycle after a read; hold it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (pipe_v[0]) begin
            rdata_q <= sram_rd;
        end
    end

    assign rsp_rdata = rdata_q;
`else
    assign rsp_rdata = pipe_v[0] ? sram_rd : '0;
`endif

endmodule
